// File: rtl/fpany_pkg.sv
// Shared widths and field helpers for the fpany multiplier/partial-sum formats.
// Formats are {sign, expo, mant}; both share bias 2**(MULT_EXPO_W-1)-1.
package fpany_pkg;

  localparam int unsigned MULT_EXPO_W = 3;
  localparam int unsigned MULT_MANT_W = 4;
  localparam int unsigned PSUM_EXPO_W = MULT_EXPO_W + 3;
  localparam int unsigned PSUM_MANT_W = MULT_MANT_W + 1;

  localparam int unsigned FP_MULT_W  = 1 + MULT_EXPO_W + MULT_MANT_W;
  localparam int unsigned FP_PSUM_W  = 1 + PSUM_EXPO_W + PSUM_MANT_W;
  localparam int unsigned ROUND_DROP = PSUM_MANT_W - MULT_MANT_W;

  function automatic logic get_sign(input logic [FP_PSUM_W-1:0] w);
    return w[FP_PSUM_W-1];
  endfunction

  function automatic logic [PSUM_EXPO_W-1:0] get_expo(input logic [FP_PSUM_W-1:0] w);
    return w[FP_PSUM_W-2 -: PSUM_EXPO_W];
  endfunction

  function automatic logic [PSUM_MANT_W-1:0] get_mant(input logic [FP_PSUM_W-1:0] w);
    return w[PSUM_MANT_W-1:0];
  endfunction

endpackage

// File: rtl/fpany_pipe_stage.sv
// Single valid/ready register slice; accepts whenever empty or draining.
module fpany_pipe_stage
  import fpany_pkg::*;
#(
  parameter int unsigned W = FP_MULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign in_ready  = !r_valid || out_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (in_ready) begin
      r_valid <= in_valid;
      if (in_valid) r_data <= in_data;
    end
  end

endmodule

// File: rtl/fpany_narrow_stream.sv
// Narrows a PSUM-format float to MULT format: round half-up in stage 1,
// range check / saturate / pack in stage 2, plus a saturation event counter.
module fpany_narrow_stream
  import fpany_pkg::*;
#(
  parameter int unsigned EXPO_WIDTH_MULT = MULT_EXPO_W,
  parameter int unsigned MANT_WIDTH_MULT = MULT_MANT_W,
  parameter int unsigned EXPO_WIDTH_PSUM = EXPO_WIDTH_MULT + 3,
  parameter int unsigned MANT_WIDTH_PSUM = MANT_WIDTH_MULT + 1,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [EXPO_WIDTH_PSUM+MANT_WIDTH_PSUM:0]   in_psum,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [EXPO_WIDTH_MULT+MANT_WIDTH_MULT:0]   out_fp,
  output logic                                       out_sat,
  input  logic                                       clr_cnt,
  output logic [CNT_WIDTH-1:0]                       sat_cnt
);

  localparam int unsigned EM   = EXPO_WIDTH_MULT;
  localparam int unsigned MM   = MANT_WIDTH_MULT;
  localparam int unsigned EP   = EXPO_WIDTH_PSUM;
  localparam int unsigned MP   = MANT_WIDTH_PSUM;
  localparam int unsigned D    = MP - MM;
  localparam int unsigned PW   = 1 + EP + MP;
  localparam int unsigned FW   = 1 + EM + MM;
  localparam int unsigned S1_W = 1 + (EP + 1) + MM;
  localparam int unsigned S2_W = 1 + FW;
  localparam logic [EP:0] EXPO_MAX = (EP+1)'((1 << EM) - 1);

  logic          w_sign;
  logic [EP-1:0] w_expo;
  logic [MP-1:0] w_mant;
  logic [MM:0]   w_mant_sum;
  logic [EP:0]   w_expo_r;
  logic [S1_W-1:0] w_s1_in, w_s1_q;
  logic          w_s1_valid, w_s1_adv;
  logic          w_s1_sign;
  logic [EP:0]   w_s1_expo;
  logic [MM-1:0] w_s1_mant;
  logic          w_sat;
  logic [S2_W-1:0] w_s2_in, w_s2_q;
  logic [CNT_WIDTH-1:0] r_sat_cnt;

  assign w_sign = in_psum[PW-1];
  assign w_expo = in_psum[PW-2 -: EP];
  assign w_mant = in_psum[MP-1:0];

  // Extra exponent bit keeps the rounding carry visible to the range check.
  assign w_mant_sum = {1'b0, w_mant[MP-1:D]} + {{MM{1'b0}}, w_mant[D-1]};
  assign w_expo_r   = {1'b0, w_expo} + {{EP{1'b0}}, w_mant_sum[MM]};
  assign w_s1_in    = {w_sign, w_expo_r, w_mant_sum[MM-1:0]};

  fpany_pipe_stage #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_s1_in),
    .out_valid (w_s1_valid),
    .out_ready (w_s1_adv),
    .out_data  (w_s1_q)
  );

  assign w_s1_sign = w_s1_q[S1_W-1];
  assign w_s1_expo = w_s1_q[MM +: EP+1];
  assign w_s1_mant = w_s1_q[MM-1:0];
  assign w_sat     = w_s1_expo > EXPO_MAX;

  always_comb begin
    w_s2_in = '0;
    w_s2_in[S2_W-1] = w_sat;
    w_s2_in[FW-1]   = w_s1_sign;
    if (w_sat) w_s2_in[FW-2:0] = '1;
    else       w_s2_in[FW-2:0] = {w_s1_expo[EM-1:0], w_s1_mant};
  end

  fpany_pipe_stage #(.W(S2_W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_s1_valid),
    .in_ready  (w_s1_adv),
    .in_data   (w_s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_s2_q)
  );

  assign out_fp  = w_s2_q[FW-1:0];
  assign out_sat = w_s2_q[S2_W-1];

  always_ff @(posedge clk) begin
    if (rst || clr_cnt)
      r_sat_cnt <= '0;
    else if (out_valid && out_ready && out_sat && (r_sat_cnt != '1))
      r_sat_cnt <= r_sat_cnt + 1'b1;
  end

  assign sat_cnt = r_sat_cnt;

endmodule

// File: tb/tb_fpany_narrow_stream.sv
// Randomized and directed checks of fpany_narrow_stream against an arithmetic model.
module tb_fpany_narrow_stream;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready, out_sat, clr_cnt;
  logic [11:0] in_psum;
  logic [7:0]  out_fp;
  logic [15:0] sat_cnt;
  logic        in_ready2, out_valid2, out_sat2;
  logic [7:0]  out_fp2;
  logic [1:0]  sat_cnt2;

  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] q[$];
  int unsigned mcnt = 0, mcnt2 = 0;

  fpany_narrow_stream u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_psum(in_psum),
    .out_valid(out_valid), .out_ready(out_ready), .out_fp(out_fp), .out_sat(out_sat),
    .clr_cnt(clr_cnt), .sat_cnt(sat_cnt)
  );

  fpany_narrow_stream #(.CNT_WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_psum(in_psum),
    .out_valid(out_valid2), .out_ready(out_ready), .out_fp(out_fp2), .out_sat(out_sat2),
    .clr_cnt(clr_cnt), .sat_cnt(sat_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Expected {sat, fp}: round-half-up via (m + half) >> drop, then range check.
  function automatic logic [8:0] model(input logic [11:0] p);
    int unsigned s, e, m, mr;
    logic [8:0] r;
    s  = p[11];
    e  = p[10:5];
    m  = p[4:0];
    mr = (m + 1) >> 1;
    if (mr >= 16) begin
      mr = mr - 16;
      e  = e + 1;
    end
    if (e > 7) r = {1'b1, s[0], 7'h7F};
    else       r = {1'b0, s[0], e[2:0], mr[3:0]};
    return r;
  endfunction

  always @(negedge clk) begin
    logic [8:0] exp_v;
    if (rst) begin
      q.delete();
      mcnt  = 0;
      mcnt2 = 0;
    end else begin
      chk("sat_cnt", {16'b0, sat_cnt}, mcnt);
      chk("sat_cnt_w2", {30'b0, sat_cnt2}, mcnt2);
      chk("in_ready", {31'b0, in_ready}, {31'b0, (q.size() < 2) || out_ready});
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          exp_v = q[0];
          chk("out_fp", {24'b0, out_fp}, {24'b0, exp_v[7:0]});
          chk("out_sat", {31'b0, out_sat}, {31'b0, exp_v[8]});
          if (out_ready) begin
            void'(q.pop_front());
            if (clr_cnt) begin
              mcnt = 0; mcnt2 = 0;
            end else if (exp_v[8]) begin
              if (mcnt < 65535) mcnt++;
              if (mcnt2 < 3) mcnt2++;
            end
          end else if (clr_cnt) begin
            mcnt = 0; mcnt2 = 0;
          end
        end
      end else if (clr_cnt) begin
        mcnt = 0; mcnt2 = 0;
      end
      if (in_valid && in_ready) q.push_back(model(in_psum));
    end
  end

  task automatic send_lit(input logic [11:0] p, input logic [7:0] efp, input logic esat,
                          input string nm);
    int unsigned k;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_psum  = p;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 20);
    if (!in_ready) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_valid_at_1"}, {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk({nm, "_valid_at_2"}, {31'b0, out_valid}, 32'd1);
    chk({nm, "_fp"}, {24'b0, out_fp}, {24'b0, efp});
    chk({nm, "_sat"}, {31'b0, out_sat}, {31'b0, esat});
  endtask

  initial begin
    logic [7:0] got[3];
    int unsigned n, k;
    logic acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0; in_psum = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_fp", {24'b0, out_fp}, 32'd0);
    chk("rst_out_sat", {31'b0, out_sat}, 32'd0);
    chk("rst_sat_cnt", {16'b0, sat_cnt}, 32'd0);

    // model pins
    chk("model_076", {23'b0, model(12'h076)}, 32'h03B);
    chk("model_07F", {23'b0, model(12'h07F)}, 32'h040);
    chk("model_900", {23'b0, model(12'h900)}, 32'h1FF);

    send_lit(12'h076, 8'h3B, 1'b0, "plain");
    send_lit(12'h077, 8'h3C, 1'b0, "round");
    send_lit(12'h07F, 8'h40, 1'b0, "carry");
    send_lit(12'h100, 8'h7F, 1'b1, "sat_e8");
    send_lit(12'h900, 8'hFF, 1'b1, "sat_neg");
    send_lit(12'h0FF, 8'h7F, 1'b1, "sat_carry");
    @(negedge clk);
    chk("sat_cnt_after3", {16'b0, sat_cnt}, 32'd3);

    // backpressure
    @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b1; in_psum = 12'h076;
    @(posedge clk); #1 in_psum = 12'h077;
    @(posedge clk); #1 in_psum = 12'h07F;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_hold_fp", {24'b0, out_fp}, 32'h3B);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    n = 0; k = 0;
    while (n < 3 && k < 12) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        got[n] = out_fp;
        n++;
      end
      acc = in_valid && in_ready;
      k++;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    chk("bp_count", n, 32'd3);
    if (n == 3) begin
      chk("bp_out0", {24'b0, got[0]}, 32'h3B);
      chk("bp_out1", {24'b0, got[1]}, 32'h3C);
      chk("bp_out2", {24'b0, got[2]}, 32'h40);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);

    // clear wins over a simultaneous saturated transfer
    @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b1; in_psum = 12'h100;
    @(posedge clk); #1 in_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 10);
    chk("clr_wait_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1 clr_cnt = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr_priority", {16'b0, sat_cnt}, 32'd0);
    chk("clr_priority_w2", {30'b0, sat_cnt2}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 in_valid = 1'b1; in_psum = 12'h100 + 12'(i);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("five_sat", {16'b0, sat_cnt}, 32'd5);
    chk("five_sat_w2_held", {30'b0, sat_cnt2}, 32'd3);

    // reset mid-stream
    @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b1; in_psum = 12'h076;
    @(posedge clk); #1 in_psum = 12'h100;
    @(posedge clk); #1 in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_sat_cnt", {16'b0, sat_cnt}, 32'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_emit", {31'b0, out_valid}, 32'd0);
    end

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_cnt   = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 3) != 0)
        in_psum = {1'($urandom_range(0, 1)), 6'($urandom_range(0, 9)), 5'($urandom_range(0, 31))};
      else
        in_psum = 12'($urandom);
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
    repeat (6) @(negedge clk);
    chk("drain_empty", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
